// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with ready/load handshake and frame/last strobes.
// Words can follow each other with no gap: a load taken while last=1 starts the next word directly.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             q,
  output logic             frame,
  output logic             last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             first_bit;
  logic             next_bit;

  assign ready     = (state == IDLE) | last;
  assign accept    = load & ready;
  assign first_bit = MSB_FIRST ? d[WIDTH-1] : d[0];
  // q always mirrors the outgoing end of sr, so the next bit is its neighbour.
  assign next_bit  = MSB_FIRST ? sr[WIDTH-2] : sr[1];

  // NOTE: all state, outputs included, is assigned with <= in one clocked block so every
  // register sees the pre-edge values of its neighbours; reset is synchronous and wins over load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      q     <= 1'b0;
      frame <= 1'b0;
      last  <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      sr    <= d;
      cnt   <= '0;
      q     <= first_bit;
      frame <= 1'b1;
      last  <= 1'b0;
    end else if (state == SHIFT && !last) begin
      sr    <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      q     <= next_bit;
      last  <= ((cnt + 1'b1) == CNT_LAST);
    end else begin
      // Idle with no load, or end of word with no follow-on load.
      state <= IDLE;
      q     <= 1'b0;
      frame <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a 4-bit LSB-first instance and an 8-bit MSB-first instance.
// Outputs are sampled 1 time unit after each rising edge; a falling-edge sipo model checks reassembly.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d_a;
  logic       load_a;
  logic       ready_a, q_a, frame_a, last_a;
  logic [7:0] d_b;
  logic       load_b;
  logic       ready_b, q_b, frame_b, last_b;
  logic [3:0] sipo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .load(load_a),
    .ready(ready_a), .q(q_a), .frame(frame_a), .last(last_a)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .load(load_b),
    .ready(ready_b), .q(q_b), .frame(frame_b), .last(last_b)
  );

  // Receiver: LSB-first word lands in sipo[3:0] after four falling edges.
  always @(negedge clk) sipo <= {q_a, sipo[3:1]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq;

    // Reset with a load request pending: reset must win on both edges.
    rst_n = 1'b0; load_a = 1'b1; d_a = 4'hF; load_b = 1'b0; d_b = 8'h00;
    for (int e = 0; e < 2; e++) begin
      tick();
      check($sformatf("rst_q_%0d", e),     q_a,     1'b0);
      check($sformatf("rst_frame_%0d", e), frame_a, 1'b0);
      check($sformatf("rst_last_%0d", e),  last_a,  1'b0);
      check($sformatf("rst_ready_%0d", e), ready_a, 1'b1);
      check($sformatf("rst_b_frame_%0d", e), frame_b, 1'b0);
    end
    rst_n = 1'b1; load_a = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      check($sformatf("idle_q_%0d", e),     q_a,     1'b0);
      check($sformatf("idle_frame_%0d", e), frame_a, 1'b0);
    end

    // Single word 4'b1011, LSB first: 1,1,0,1.
    seq = 8'b0000_1011;
    d_a = 4'b1011; load_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      load_a = 1'b0; d_a = 4'h0;
      check($sformatf("single_q_%0d", k),     q_a,     seq[k]);
      check($sformatf("single_frame_%0d", k), frame_a, 1'b1);
      check($sformatf("single_last_%0d", k),  last_a,  (k == 3));
    end
    tick();
    check("single_end_q",     q_a,     1'b0);
    check("single_end_frame", frame_a, 1'b0);
    check("single_end_ready", ready_a, 1'b1);
    check("single_sipo",      sipo,    4'b1011);

    // Back to back: 4'hA then 4'h5 loaded while last=1.
    seq = 8'b0101_1010;
    d_a = 4'hA; load_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("b2b_q_%0d", k),     q_a,     seq[k]);
      check($sformatf("b2b_frame_%0d", k), frame_a, 1'b1);
      check($sformatf("b2b_last_%0d", k),  last_a,  (k == 3 || k == 7));
      check($sformatf("b2b_ready_%0d", k), ready_a, (k == 3 || k == 7));
      if (k == 3) begin
        load_a = 1'b1; d_a = 4'h5;
      end else begin
        load_a = 1'b0; d_a = 4'h0;
      end
    end
    tick();
    check("b2b_end_frame", frame_a, 1'b0);

    // Load while busy: 4'h3 offered at edges 1 and 2 must be ignored.
    seq = 8'b0000_1100;
    d_a = 4'hC; load_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 2) begin
        load_a = 1'b1; d_a = 4'h3;
      end else begin
        load_a = 1'b0; d_a = 4'h0;
      end
      check($sformatf("busy_q_%0d", k),    q_a,    seq[k]);
      check($sformatf("busy_last_%0d", k), last_a, (k == 3));
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      check($sformatf("busy_after_frame_%0d", e), frame_a, 1'b0);
      check($sformatf("busy_after_q_%0d", e),     q_a,     1'b0);
    end

    // Reset mid-frame: 4'hF loaded at edge 0, reset at edge 2, 4'h6 loaded at edge 3.
    d_a = 4'hF; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    check("rmid_q0", q_a, 1'b1);
    tick();
    check("rmid_q1", q_a, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rmid_q",     q_a,     1'b0);
    check("rmid_frame", frame_a, 1'b0);
    check("rmid_last",  last_a,  1'b0);
    check("rmid_ready", ready_a, 1'b1);
    rst_n = 1'b1; d_a = 4'h6; load_a = 1'b1;
    seq = 8'b0000_0110;
    for (int k = 0; k < 4; k++) begin
      tick();
      load_a = 1'b0; d_a = 4'h0;
      check($sformatf("rnew_q_%0d", k),     q_a,     seq[k]);
      check($sformatf("rnew_frame_%0d", k), frame_a, 1'b1);
      check($sformatf("rnew_last_%0d", k),  last_a,  (k == 3));
    end
    tick();
    check("rnew_end_frame", frame_a, 1'b0);

    // WIDTH=8, MSB first, 8'hA5: 1,0,1,0,0,1,0,1.
    seq = 8'b1010_0101;
    d_b = 8'hA5; load_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      load_b = 1'b0; d_b = 8'h00;
      check($sformatf("w8_q_%0d", k),     q_b,     seq[7-k]);
      check($sformatf("w8_frame_%0d", k), frame_b, 1'b1);
      check($sformatf("w8_last_%0d", k),  last_b,  (k == 7));
    end
    tick();
    check("w8_end_frame", frame_b, 1'b0);
    check("w8_end_ready", ready_b, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
